mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port main memory between the IF stage (instruction fetch) and the MEM stage (loads and stores) of the RV32IM pipeline.
- Takes MEM-stage requests in the encodings produced by the ID-stage decoder:
  - `d_read[3]` is the load enable; `d_read[2:0]` is funct3.
  - `d_write[2]` is the store enable; `d_write[1:0]` is funct3[1:0].
- Sequences one memory transaction at a time and stalls each requester through its busywait.
- Performs store byte-lane steering and load extraction/sign-extension, so the memory sees only aligned 32-bit words with byte enables.

## Interface
Parameters:
- none

Ports:
- `CLK` input 1: clock; all state updates on rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `if_read` input 1: instruction fetch request.
- `if_address` input 32: fetch address; bits [1:0] ignored.
- `if_readdata` output 32: fetched instruction word.
- `if_busywait` output 1: fetch stall.
- `d_read` input 4: [3] load enable; [2:0] funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `d_write` input 3: [2] store enable; [1:0] size (00 SB, 01 SH, 10 SW).
- `d_address` input 32: data byte address.
- `d_writedata` input 32: store data, LSB-aligned.
- `d_readdata` output 32: extended load result.
- `d_busywait` output 1: MEM-stage stall.
- `d_misaligned` output 1: one-cycle flag; access rejected.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `mem_address` output 30: word address (byte address [31:2]).
- `mem_writedata` output 32: lane-steered write data.
- `mem_byteen` output 4: byte enables; bit i covers bits [8i+7:8i].
- `mem_readdata` input 32: read word, valid when `mem_ready`=1.
- `mem_ready` input 1: one-cycle completion pulse from memory.

## Operation
FSM states:
- **IDLE**: no memory strobes asserted.
  - Data request pending and aligned → D_ACC.
  - Data request pending and misaligned → D_DONE with `d_misaligned`.
  - Only a fetch pending → I_ACC.
  - Data always wins a simultaneous request.
- **D_ACC / I_ACC**:
  - Strobes, address, writedata and byteen are driven from registers latched on entry and held stable.
  - On `mem_ready`=1: capture the read word (`mem_readdata` for loads, ignored for stores), then go to D_DONE / I_DONE.
- **D_DONE / I_DONE**: one cycle. The owning busywait is low and the readdata register is valid. Next state is IDLE.

Busywait generation:
- `d_busywait` = (`d_read[3]` | `d_write[2]`) & ~(state==D_DONE).
- `if_busywait` = `if_read` & ~(state==I_DONE).
- Both are combinational and forced to 0 while RESET is high.

Request decoding:
- If `d_write[2]` and `d_read[3]` are both set, the request is a store.

Misalignment:
- A halfword access is misaligned when addr[0]=1.
- A word access is misaligned when addr[1:0]≠00.
- Misaligned requests generate no memory strobe and complete via D_DONE with `d_readdata`=0.

Store steering, by size:
- SB: byteen = 0001 << addr[1:0]; writedata = byte replicated ×4.
- SH: byteen = 0011 << addr[1:0]; writedata = half replicated ×2.
- SW: byteen = 1111.

Load extraction and extension:
- Lane is selected by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reads drive byteen=1111.

Hold behaviour:
- `d_readdata` and `if_readdata` hold their last captured value until the next capture for that requester.

## Timing
Reset:
- State=IDLE.
- `mem_read`=`mem_write`=0; `mem_address`=0, `mem_writedata`=0, `mem_byteen`=0.
- `if_readdata`=`d_readdata`=0; `d_misaligned`=0.

Latency:
- Request visible in cycle 0 (IDLE). Strobes asserted from cycle 1.
- With `mem_ready` in cycle k≥1, DONE is cycle k+1, and the requester advances at the end of cycle k+1.
- Minimum is 3 cycles with 2 stall edges.

Misaligned path:
- Request in cycle 0; D_DONE with `d_misaligned`=1 in cycle 1.

DONE state rules:
- In DONE, no new request is accepted, even if one is pending.
- `mem_ready` outside D_ACC/I_ACC is ignored.

Fetch waiting behind data:
- A fetch waiting behind a data access keeps `if_busywait` high throughout and is issued from the next IDLE.

Reset mid-access:
- Strobes drop immediately (asynchronously).
- The captured data is discarded and the FSM returns to IDLE.

## Test plan
- **Reset:** assert RESET mid-I_ACC → `mem_read`=0 the same cycle. After release, all outputs are 0 and the FSM is in IDLE.
- **Fetch:** `if_read`=1 at 0x0000_0104 and memory returns 0x0010_0093 with `mem_ready` in cycle 3.
  - `mem_address`=0x41 in cycles 1–3.
  - `if_busywait` low in cycle 4 only, with `if_readdata`=0x0010_0093.
- **Contention:** `if_read` and LW at 0x200 arrive in the same cycle → data served first, then the fetch. `if_busywait` stays high until I_DONE.
- **Store steering:**
  - SB 0x...A5 at 0x103 → byteen 1000, writedata 0xA5A5A5A5.
  - SH 0xBEEF at 0x102 → byteen 1100, writedata 0xBEEFBEEF.
- **Load extension:** `mem_readdata`=0x80F0_7F01.
  - LB @+3 → 0xFFFF_FF80.
  - LBU @+3 → 0x0000_0080.
  - LH @+2 → 0xFFFF_80F0.
  - LHU @+0 → 0x0000_7F01.
- **Misaligned:** LW at 0x102 → no strobe; cycle 1 has `d_misaligned`=1, `d_busywait`=0 and `d_readdata`=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the MEM stage. One transaction at a time, data has priority, stores are
// lane-steered and loads are extracted/extended so memory only sees aligned
// 32-bit words with byte enables.
module mem_port_arbiter (
    input  logic        CLK,
    input  logic        RESET,
    // instruction fetch port
    input  logic        if_read,
    input  logic [31:0] if_address,
    output logic [31:0] if_readdata,
    output logic        if_busywait,
    // MEM-stage port
    input  logic [3:0]  d_read,
    input  logic [2:0]  d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_busywait,
    output logic        d_misaligned,
    // memory side
    output logic        mem_read,
    output logic        mem_write,
    output logic [29:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_readdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ACC  = 3'd1,
        I_ACC  = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        mrd_q, mrd_d;
    logic        mwr_q, mwr_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        mis_q, mis_d;

    // Fetch words are always aligned; the low address bits carry no meaning.
    logic unused_if_addr_lo;
    assign unused_if_addr_lo = ^if_address[1:0];

    // Request decode: a store wins when both enables are set.
    logic       d_store, d_load, d_req, d_mis;
    logic [1:0] d_size;
    assign d_store = d_write[2];
    assign d_load  = d_read[3] & ~d_write[2];
    assign d_req   = d_store | d_load;
    assign d_size  = d_store ? d_write[1:0] : d_read[1:0];
    assign d_mis   = ((d_size == 2'b01) & d_address[0]) |
                     (d_size[1] & (|d_address[1:0]));

    // Store lane steering: replicate the datum into every lane, enable the target lanes.
    logic [3:0]  st_be;
    logic [31:0] st_wd;
    always_comb begin
        st_be = 4'b1111;
        st_wd = d_writedata;
        case (d_size)
            2'b00: begin
                st_be = 4'b0001 << d_address[1:0];
                st_wd = {4{d_writedata[7:0]}};
            end
            2'b01: begin
                st_be = 4'b0011 << d_address[1:0];
                st_wd = {2{d_writedata[15:0]}};
            end
            default: begin
                st_be = 4'b1111;
                st_wd = d_writedata;
            end
        endcase
    end

    // Load extraction: shift the selected lane down, then sign/zero extend by funct3.
    logic [31:0] ld_shift, ld_ext;
    assign ld_shift = mem_readdata >> {lane_q, 3'b000};
    always_comb begin
        ld_ext = mem_readdata;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = mem_readdata;
        endcase
    end

    // Next-state and register-next logic; access registers are latched on ACC entry.
    always_comb begin
        state_d    = state_q;
        mrd_d      = mrd_q;
        mwr_d      = mwr_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        be_d       = be_q;
        f3_d       = f3_q;
        lane_d     = lane_q;
        d_rdata_d  = d_rdata_q;
        if_rdata_d = if_rdata_q;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    if (d_mis) begin
                        state_d   = D_DONE;
                        mis_d     = 1'b1;
                        d_rdata_d = 32'd0;
                    end else begin
                        state_d = D_ACC;
                        mrd_d   = d_load;
                        mwr_d   = d_store;
                        addr_d  = d_address[31:2];
                        be_d    = d_store ? st_be : 4'b1111;
                        wd_d    = d_store ? st_wd : 32'd0;
                        f3_d    = d_read[2:0];
                        lane_d  = d_address[1:0];
                    end
                end else if (if_read) begin
                    state_d = I_ACC;
                    mrd_d   = 1'b1;
                    mwr_d   = 1'b0;
                    addr_d  = if_address[31:2];
                    be_d    = 4'b1111;
                    wd_d    = 32'd0;
                end
            end
            D_ACC: begin
                if (mem_ready) begin
                    state_d = D_DONE;
                    mrd_d   = 1'b0;
                    mwr_d   = 1'b0;
                    if (mrd_q) d_rdata_d = ld_ext;
                end
            end
            I_ACC: begin
                if (mem_ready) begin
                    state_d    = I_DONE;
                    mrd_d      = 1'b0;
                    if_rdata_d = mem_readdata;
                end
            end
            D_DONE:  state_d = IDLE;
            I_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and access registers; reset clears strobes immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            mrd_q      <= 1'b0;
            mwr_q      <= 1'b0;
            addr_q     <= 30'd0;
            wd_q       <= 32'd0;
            be_q       <= 4'd0;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            d_rdata_q  <= 32'd0;
            if_rdata_q <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mrd_q      <= mrd_d;
            mwr_q      <= mwr_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            lane_q     <= lane_d;
            d_rdata_q  <= d_rdata_d;
            if_rdata_q <= if_rdata_d;
            mis_q      <= mis_d;
        end
    end

    assign mem_read      = mrd_q;
    assign mem_write     = mwr_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wd_q;
    assign mem_byteen    = be_q;
    assign d_readdata    = d_rdata_q;
    assign if_readdata   = if_rdata_q;
    assign d_misaligned  = mis_q;

    // Stalls release only in the owner's DONE cycle.
    assign d_busywait  = ~RESET & (d_read[3] | d_write[2]) & (state_q != D_DONE);
    assign if_busywait = ~RESET & if_read & (state_q != I_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A transaction-level model sets the
// expected per-cycle outputs; one negedge process compares them, and literal
// checks pin the model on the documented examples.
module tb_mem_port_arbiter;

    logic        CLK, RESET;
    logic        if_read;
    logic [31:0] if_address, if_readdata;
    logic        if_busywait;
    logic [3:0]  d_read;
    logic [2:0]  d_write;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic        d_busywait, d_misaligned;
    logic        mem_read, mem_write;
    logic [29:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_readdata;
    logic        mem_ready;

    mem_port_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .if_read(if_read), .if_address(if_address),
        .if_readdata(if_readdata), .if_busywait(if_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_readdata(d_readdata),
        .d_busywait(d_busywait), .d_misaligned(d_misaligned),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_byteen(mem_byteen), .mem_readdata(mem_readdata),
        .mem_ready(mem_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;

    // expected outputs for the current cycle
    logic        chk_en;
    logic        e_mrd, e_mwr, e_dbusy, e_ibusy, e_mis;
    logic [29:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_drd, e_ird;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // byte enables: n consecutive lanes starting at the offset
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        int n;
        logic [3:0] r;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        r = 4'd0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(off) && i < int'(off) + n) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] b, h;
        b = {24'd0, wd[7:0]};
        h = {16'd0, wd[15:0]};
        if (sz == 2'd0) return b * 32'h0101_0101;
        if (sz == 2'd1) return h * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  by [4];
        logic [31:0] v;
        int o;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        o = int'(off);
        v = w;
        if (f3[1:0] == 2'd0) begin
            v = {24'd0, by[o]};
            if (!f3[2] && by[o][7]) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'd1) begin
            v = {16'd0, by[o+1], by[o]};
            if (!f3[2] && by[o+1][7]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // per-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("mem_read", {31'd0, mem_read}, {31'd0, e_mrd});
            chk("mem_write", {31'd0, mem_write}, {31'd0, e_mwr});
            chk("d_busywait", {31'd0, d_busywait}, {31'd0, e_dbusy});
            chk("if_busywait", {31'd0, if_busywait}, {31'd0, e_ibusy});
            chk("d_misaligned", {31'd0, d_misaligned}, {31'd0, e_mis});
            chk("d_readdata", d_readdata, e_drd);
            chk("if_readdata", if_readdata, e_ird);
            if (e_mrd || e_mwr) begin
                chk("mem_address", {2'd0, mem_address}, {2'd0, e_addr});
                chk("mem_byteen", {28'd0, mem_byteen}, {28'd0, e_be});
            end
            if (e_mwr) chk("mem_writedata", mem_writedata, e_wd);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // lit: 0 none, 1 store lanes (la=byteen, lb=wdata), 2 load result (lb), 3 misaligned
    task automatic data_txn(input bit st, input bit both, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int k,
                            input logic [31:0] word, input bit fwait,
                            input int lit, input logic [31:0] la, input logic [31:0] lb);
        logic [1:0] sz;
        bit mis;
        sz  = f3[1:0];
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        d_read      = st ? (both ? 4'b1010 : 4'b0000) : {1'b1, f3};
        d_write     = st ? {1'b1, sz} : 3'b000;
        d_address   = a;
        d_writedata = wd;
        e_mrd = 1'b0; e_mwr = 1'b0; e_mis = 1'b0;
        e_dbusy = 1'b1; e_ibusy = fwait;
        if (mis) begin
            step();
            e_mis = 1'b1; e_dbusy = 1'b0; e_drd = 32'd0;
            if (lit == 3) begin
                #2;
                chk("lit_mis_flag", {31'd0, d_misaligned}, 32'd1);
                chk("lit_mis_busy", {31'd0, d_busywait}, 32'd0);
                chk("lit_mis_rdata", d_readdata, 32'd0);
                chk("lit_mis_nostrobe", {30'd0, mem_read, mem_write}, 32'd0);
            end
        end else begin
            for (int c = 1; c <= k; c++) begin
                step();
                e_mrd = !st; e_mwr = st;
                e_addr = a[31:2];
                e_be = st ? m_be(sz, a[1:0]) : 4'hF;
                e_wd = m_wd(sz, wd);
                mem_ready    = (c == k);
                mem_readdata = (c == k) ? word : 32'h0BAD_0000 + c;
                if (lit == 1 && c == 1) begin
                    #2;
                    chk("lit_st_byteen", {28'd0, mem_byteen}, la);
                    chk("lit_st_wdata", mem_writedata, lb);
                end
            end
            step();
            // stray ready in DONE must be ignored
            mem_ready = 1'b1; mem_readdata = 32'hDEAD_BEEF;
            e_mrd = 1'b0; e_mwr = 1'b0; e_dbusy = 1'b0;
            if (!st) e_drd = m_ld(f3, a[1:0], word);
            if (lit == 2) begin
                #2;
                chk("lit_ld_rdata", d_readdata, lb);
            end
        end
        step();
        mem_ready = 1'b0;
        d_read = 4'd0; d_write = 3'd0;
        e_mis = 1'b0; e_dbusy = 1'b0; e_ibusy = fwait;
    endtask

    task automatic fetch_txn(input logic [31:0] a, input int k, input logic [31:0] word,
                             input bit lit, input logic [29:0] la, input logic [31:0] lr);
        if_read = 1'b1; if_address = a;
        e_mrd = 1'b0; e_mwr = 1'b0; e_dbusy = 1'b0; e_ibusy = 1'b1; e_mis = 1'b0;
        for (int c = 1; c <= k; c++) begin
            step();
            e_mrd = 1'b1; e_addr = a[31:2]; e_be = 4'hF;
            mem_ready    = (c == k);
            mem_readdata = (c == k) ? word : 32'h0BAD_1000 + c;
            if (lit) begin
                #2;
                chk("lit_fetch_addr", {2'd0, mem_address}, {2'd0, la});
            end
        end
        step();
        mem_ready = 1'b1; mem_readdata = 32'hDEAD_BEEF;
        e_mrd = 1'b0; e_ibusy = 1'b0; e_ird = word;
        if (lit) begin
            #2;
            chk("lit_fetch_data", if_readdata, lr);
            chk("lit_fetch_busy", {31'd0, if_busywait}, 32'd0);
        end
        step();
        mem_ready = 1'b0; if_read = 1'b0; e_ibusy = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
        chk({tag, "_mem_address"}, {2'd0, mem_address}, 32'd0);
        chk({tag, "_mem_writedata"}, mem_writedata, 32'd0);
        chk({tag, "_mem_byteen"}, {28'd0, mem_byteen}, 32'd0);
        chk({tag, "_if_readdata"}, if_readdata, 32'd0);
        chk({tag, "_d_readdata"}, d_readdata, 32'd0);
        chk({tag, "_d_misaligned"}, {31'd0, d_misaligned}, 32'd0);
    endtask

    initial begin
        RESET = 1'b1; chk_en = 1'b0;
        if_read = 1'b0; if_address = 32'd0;
        d_read = 4'd0; d_write = 3'd0; d_address = 32'd0; d_writedata = 32'd0;
        mem_readdata = 32'd0; mem_ready = 1'b0;
        e_mrd = 0; e_mwr = 0; e_dbusy = 0; e_ibusy = 0; e_mis = 0;
        e_addr = '0; e_be = '0; e_wd = '0; e_drd = '0; e_ird = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("rst");
        RESET = 1'b0;
        chk_en = 1'b1;
        step(); step();

        // fetch with ready in cycle 3
        fetch_txn(32'h0000_0104, 3, 32'h0010_0093, 1'b1, 30'h41, 32'h0010_0093);
        // store steering
        data_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h1234_56A5, 1, 32'd0, 1'b0, 1, 32'h8, 32'hA5A5_A5A5);
        data_txn(1'b1, 1'b0, 3'b001, 32'h102, 32'h0000_BEEF, 2, 32'd0, 1'b0, 1, 32'hC, 32'hBEEF_BEEF);
        // read and write enables both set: treated as a word store
        data_txn(1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 1, 32'd0, 1'b0, 1, 32'hF, 32'hCAFE_F00D);
        // load extraction
        data_txn(1'b0, 1'b0, 3'b000, 32'h303, 32'd0, 1, 32'h80F0_7F01, 1'b0, 2, 32'd0, 32'hFFFF_FF80);
        data_txn(1'b0, 1'b0, 3'b100, 32'h303, 32'd0, 2, 32'h80F0_7F01, 1'b0, 2, 32'd0, 32'h0000_0080);
        data_txn(1'b0, 1'b0, 3'b001, 32'h302, 32'd0, 1, 32'h80F0_7F01, 1'b0, 2, 32'd0, 32'hFFFF_80F0);
        data_txn(1'b0, 1'b0, 3'b101, 32'h300, 32'd0, 1, 32'h80F0_7F01, 1'b0, 2, 32'd0, 32'h0000_7F01);
        // misaligned word load and halfword store
        data_txn(1'b0, 1'b0, 3'b010, 32'h102, 32'd0, 1, 32'd0, 1'b0, 3, 32'd0, 32'd0);
        data_txn(1'b1, 1'b0, 3'b001, 32'h205, 32'h1111_2222, 1, 32'd0, 1'b0, 0, 32'd0, 32'd0);
        // contention: data first, fetch waits and follows
        if_read = 1'b1; if_address = 32'h300;
        data_txn(1'b0, 1'b0, 3'b010, 32'h200, 32'd0, 2, 32'h1234_5678, 1'b1, 2, 32'd0, 32'h1234_5678);
        fetch_txn(32'h300, 1, 32'h0000_0013, 1'b0, 30'd0, 32'd0);

        // reset in the middle of a fetch access
        if_read = 1'b1; if_address = 32'h500;
        e_ibusy = 1'b1;
        step();
        e_mrd = 1'b1; e_addr = 30'h140; e_be = 4'hF;
        #2;
        chk("pre_rst_mem_read", {31'd0, mem_read}, 32'd1);
        chk_en = 1'b0;
        RESET = 1'b1;
        #1;
        chk("rst_mem_read_async", {31'd0, mem_read}, 32'd0);
        chk("rst_if_busywait", {31'd0, if_busywait}, 32'd0);
        if_read = 1'b0;
        step();
        RESET = 1'b0;
        #1;
        chk_all_zero("post_rst");
        e_mrd = 0; e_mwr = 0; e_dbusy = 0; e_ibusy = 0; e_mis = 0;
        e_drd = 32'd0; e_ird = 32'd0;
        chk_en = 1'b1;
        step();
        fetch_txn(32'h8, 1, 32'h0040_0113, 1'b0, 30'd0, 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
